ptx_serializer_param: RTL and testbench

//  Parametrised parallel-to-serial transmitter: time-division multiplexes LANES input lanes of

---
 rtl/ptx_pkg.sv | 21 ++
 rtl/ptx_shift_out.sv | 47 ++++
 rtl/ptx_serializer_param.sv | 126 ++++++++++++
 tb/tb_ptx_serializer_param.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ptx_pkg.sv
// ptx_pkg: shared definitions for the PTX serial transmit path.
//   PTX_COM_SYM  - default sync/comma symbol (8-bit configuration)
//   PTX_IDLE_SYM - default idle symbol (8-bit configuration)
//   ptx_state_e  - transmitter FSM state (SYNC preamble, ACTIVE lane service)
//   ptx_idx_w    - index width helper, never narrower than one bit
package ptx_pkg;

  localparam logic [7:0] PTX_COM_SYM  = 8'hBC;
  localparam logic [7:0] PTX_IDLE_SYM = 8'h7C;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } ptx_state_e;

  // Width needed to index n items; a single item still gets one bit.
  function automatic int ptx_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ptx_shift_out.sv
// ptx_shift_out: WIDTH-bit load/shift register with bit counter, MSB first.
//   clk        - serial bit clock, rising edge
//   rst_n      - asynchronous active-low reset
//   load_word  - word captured at the next word boundary
//   data_out   - current serial bit (MSB of the shift register)
//   word_start - high during the first bit of every word
//   boundary   - high in the last bit cycle of a word; the next edge loads load_word
// After reset the counter sits at WIDTH-1, so the first edge after release is a
// boundary and the first word is on the line one cycle after release.
module ptx_shift_out
  import ptx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_word,
  output logic             data_out,
  output logic             word_start,
  output logic             boundary
);

  localparam int CNT_W = ptx_idx_w(WIDTH);

  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_q;

  assign boundary = (bit_cnt == CNT_W'(WIDTH - 1));
  assign data_out = shift_q[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= CNT_W'(WIDTH - 1);
      shift_q    <= '0;
      word_start <= 1'b0;
    end else if (boundary) begin
      shift_q    <= load_word;
      bit_cnt    <= '0;
      word_start <= 1'b1;
    end else begin
      shift_q    <= {shift_q[WIDTH-2:0], 1'b0};
      bit_cnt    <= bit_cnt + 1'b1;
      word_start <= 1'b0;
    end
  end

endmodule

// File: rtl/ptx_serializer_param.sv
// ptx_serializer_param: time-division multiplexes LANES lanes of WIDTH-bit words
// onto one serial bit stream (MSB first), after a COM-symbol sync preamble.
//   clk_32f     - serial bit clock, all logic on rising edge
//   reset       - asynchronous, active-low
//   enable      - 1: lanes may be serviced; 0: only IDLE once synced
//   data_in     - lane i word at [i*WIDTH +: WIDTH]
//   valid_in    - lane i word available
//   ready_out   - lane i word taken at the next edge if valid_in[i]
//   data_out    - serial bit
//   word_start  - high during first bit of every word
//   frame_start - high during first bit of each lane-0 slot (ACTIVE only)
//   sync_done   - high once the preamble is complete
//   idle_out    - high while the previous full frame carried only IDLE
//   state_dbg   - FSM state (0 = SYNC, 1 = ACTIVE)
//
// Handshake: ready_out[i] is combinational and high for exactly one cycle per
// slot (the last bit cycle before lane i's slot) while ACTIVE and enabled. A
// word moves only when valid_in[i] and ready_out[i] are both high at a rising
// edge; otherwise the source must hold it, so nothing is dropped or repeated.
// Slots are fixed TDM: the lane pointer advances every slot regardless of valid.
module ptx_serializer_param
  import ptx_pkg::*;
#(
  parameter int               LANES      = 4,
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM_SYM    = WIDTH'(PTX_COM_SYM),
  parameter logic [WIDTH-1:0] IDLE_SYM   = WIDTH'(PTX_IDLE_SYM),
  parameter int               SYNC_WORDS = 4
) (
  input  logic                   clk_32f,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [LANES*WIDTH-1:0] data_in,
  input  logic [LANES-1:0]       valid_in,
  output logic [LANES-1:0]       ready_out,
  output logic                   data_out,
  output logic                   word_start,
  output logic                   frame_start,
  output logic                   sync_done,
  output logic                   idle_out,
  output logic                   state_dbg
);

  localparam int LANE_W = ptx_idx_w(LANES);
  localparam int SYNC_W = ptx_idx_w(SYNC_WORDS + 1);

  ptx_state_e         state;
  logic [LANE_W-1:0]  lane_ptr;
  logic [SYNC_W-1:0]  sync_cnt;
  logic               any_data;    // some lane transferred in the frame being sent
  logic               frame_seen;  // at least one ACTIVE frame has started
  logic               boundary;
  logic               transfer;
  logic [WIDTH-1:0]   slot_word;
  logic [WIDTH-1:0]   load_word;

  assign state_dbg = (state == ACTIVE);

  // Slot mux: serve only the lane the pointer selects; a missing word becomes IDLE.
  always_comb begin
    ready_out = '0;
    transfer  = 1'b0;
    slot_word = IDLE_SYM;
    for (int i = 0; i < LANES; i++) begin
      if (lane_ptr == LANE_W'(i)) begin
        ready_out[i] = (state == ACTIVE) && enable && boundary;
        if (valid_in[i] && (state == ACTIVE) && enable && boundary) begin
          transfer  = 1'b1;
          slot_word = data_in[i*WIDTH +: WIDTH];
        end
      end
    end
    load_word = (state == SYNC) ? COM_SYM : slot_word;
  end

  ptx_shift_out #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk        (clk_32f),
    .rst_n      (reset),
    .load_word  (load_word),
    .data_out   (data_out),
    .word_start (word_start),
    .boundary   (boundary)
  );

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state       <= SYNC;
      lane_ptr    <= '0;
      sync_cnt    <= '0;
      sync_done   <= 1'b0;
      frame_start <= 1'b0;
      idle_out    <= 1'b0;
      any_data    <= 1'b0;
      frame_seen  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (boundary) begin
        case (state)
          SYNC: begin
            sync_cnt <= sync_cnt + 1'b1;
            // This boundary loads the final COM word; lane service follows it.
            if (sync_cnt == SYNC_W'(SYNC_WORDS - 1)) begin
              state     <= ACTIVE;
              sync_done <= 1'b1;
            end
          end
          ACTIVE: begin
            lane_ptr <= (lane_ptr == LANE_W'(LANES - 1)) ? '0 : lane_ptr + 1'b1;
            if (lane_ptr == '0) begin
              frame_start <= 1'b1;
              frame_seen  <= 1'b1;
              // The very first lane-0 load has no finished frame to report on.
              if (frame_seen) idle_out <= ~any_data;
              any_data <= transfer;
            end else begin
              any_data <= any_data | transfer;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ptx_serializer_param.sv
module tb_ptx_serializer_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default configuration: LANES=4, WIDTH=8, SYNC_WORDS=4
  logic        reset, enable;
  logic [31:0] data_in;
  logic [3:0]  valid_in, ready_out;
  logic        data_out, word_start, frame_start, sync_done, idle_out, state_dbg;

  // second configuration: LANES=3, WIDTH=10
  logic        reset3, enable3;
  logic [29:0] data_in3;
  logic [2:0]  valid_in3, ready_out3;
  logic        data_out3, word_start3, frame_start3, sync_done3, idle_out3, state_dbg3;

  ptx_serializer_param dut (
    .clk_32f(clk), .reset(reset), .enable(enable), .data_in(data_in),
    .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out),
    .word_start(word_start), .frame_start(frame_start), .sync_done(sync_done),
    .idle_out(idle_out), .state_dbg(state_dbg)
  );

  ptx_serializer_param #(
    .LANES(3), .WIDTH(10), .COM_SYM(10'h3C5), .IDLE_SYM(10'h0F0), .SYNC_WORDS(4)
  ) dut3 (
    .clk_32f(clk), .reset(reset3), .enable(enable3), .data_in(data_in3),
    .valid_in(valid_in3), .ready_out(ready_out3), .data_out(data_out3),
    .word_start(word_start3), .frame_start(frame_start3), .sync_done(sync_done3),
    .idle_out(idle_out3), .state_dbg(state_dbg3)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit word on the default instance, sampled at negedges.
  // rdy_end is the ready vector expected in the word's last bit cycle.
  task automatic word8(input logic [7:0] w, input logic fs, input logic idl,
                       input logic [3:0] rdy_end, input string tag, input int drop_at = -1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk({tag, ":bit"}, {31'd0, data_out}, {31'd0, w[7-i]});
      if (i == 0) begin
        chk({tag, ":word_start"}, {31'd0, word_start}, 32'd1);
        chk({tag, ":frame_start"}, {31'd0, frame_start}, {31'd0, fs});
        chk({tag, ":idle_out"}, {31'd0, idle_out}, {31'd0, idl});
      end else begin
        chk({tag, ":word_start_low"}, {31'd0, word_start}, 32'd0);
      end
      if (i == 7) chk({tag, ":ready_end"}, {28'd0, ready_out}, {28'd0, rdy_end});
      else        chk({tag, ":ready_mid"}, {28'd0, ready_out}, 32'd0);
      if (i == drop_at) enable = 1'b0;
    end
  endtask

  // One 10-bit word on the 3-lane instance.
  task automatic word10(input logic [9:0] w, input logic fs, input logic [2:0] rdy_end,
                        input string tag);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk({tag, ":bit"}, {31'd0, data_out3}, {31'd0, w[9-i]});
      if (i == 0) begin
        chk({tag, ":word_start"}, {31'd0, word_start3}, 32'd1);
        chk({tag, ":frame_start"}, {31'd0, frame_start3}, {31'd0, fs});
      end
      if (i == 9) chk({tag, ":ready_end"}, {29'd0, ready_out3}, {29'd0, rdy_end});
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] wf;

  initial begin
    reset = 1'b0; enable = 1'b1; data_in = '0; valid_in = '0;
    reset3 = 1'b0; enable3 = 1'b1; data_in3 = '0; valid_in3 = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst:data_out", {31'd0, data_out}, 32'd0);
    chk("rst:word_start", {31'd0, word_start}, 32'd0);
    chk("rst:frame_start", {31'd0, frame_start}, 32'd0);
    chk("rst:sync_done", {31'd0, sync_done}, 32'd0);
    chk("rst:idle_out", {31'd0, idle_out}, 32'd0);
    chk("rst:ready_out", {28'd0, ready_out}, 32'd0);
    chk("rst:state", {31'd0, state_dbg}, 32'd0);

    // 1: preamble then idle frames
    reset = 1'b1;
    word8(8'hBC, 1'b0, 1'b0, 4'b0000, "t1_com1");
    word8(8'hBC, 1'b0, 1'b0, 4'b0000, "t1_com2");
    word8(8'hBC, 1'b0, 1'b0, 4'b0000, "t1_com3");
    chk("t1:sync_done_pre", {31'd0, sync_done}, 32'd0);
    word8(8'hBC, 1'b0, 1'b0, 4'b0001, "t1_com4");
    word8(8'h7C, 1'b1, 1'b0, 4'b0010, "t1_f1l0");
    chk("t1:sync_done", {31'd0, sync_done}, 32'd1);
    chk("t1:state", {31'd0, state_dbg}, 32'd1);
    word8(8'h7C, 1'b0, 1'b0, 4'b0100, "t1_f1l1");
    word8(8'h7C, 1'b0, 1'b0, 4'b1000, "t1_f1l2");
    word8(8'h7C, 1'b0, 1'b0, 4'b0001, "t1_f1l3");
    word8(8'h7C, 1'b1, 1'b1, 4'b0010, "t1_f2l0");
    word8(8'h7C, 1'b0, 1'b1, 4'b0100, "t1_f2l1");
    word8(8'h7C, 1'b0, 1'b1, 4'b1000, "t1_f2l2");
    word8(8'h7C, 1'b0, 1'b1, 4'b0001, "t1_f2l3");

    // 2: all lanes valid
    data_in = 32'h4433_2211; valid_in = 4'hF;
    word8(8'h11, 1'b1, 1'b1, 4'b0010, "t2_f3l0");
    word8(8'h22, 1'b0, 1'b1, 4'b0100, "t2_f3l1");
    word8(8'h33, 1'b0, 1'b1, 4'b1000, "t2_f3l2");
    word8(8'h44, 1'b0, 1'b1, 4'b0001, "t2_f3l3");
    word8(8'h11, 1'b1, 1'b0, 4'b0010, "t2_f4l0");
    word8(8'h22, 1'b0, 1'b0, 4'b0100, "t2_f4l1");
    word8(8'h33, 1'b0, 1'b0, 4'b1000, "t2_f4l2");
    word8(8'h44, 1'b0, 1'b0, 4'b0001, "t2_f4l3");

    // 3: only lane 2 valid
    data_in = 32'h00A5_0000; valid_in = 4'b0100;
    word8(8'h7C, 1'b1, 1'b0, 4'b0010, "t3_f5l0");
    word8(8'h7C, 1'b0, 1'b0, 4'b0100, "t3_f5l1");
    word8(8'hA5, 1'b0, 1'b0, 4'b1000, "t3_f5l2");
    word8(8'h7C, 1'b0, 1'b0, 4'b0001, "t3_f5l3");
    word8(8'h7C, 1'b1, 1'b0, 4'b0010, "t3_f6l0");
    word8(8'h7C, 1'b0, 1'b0, 4'b0100, "t3_f6l1");
    word8(8'hA5, 1'b0, 1'b0, 4'b1000, "t3_f6l2");
    word8(8'h7C, 1'b0, 1'b0, 4'b0001, "t3_f6l3");

    // 4: enable drops at bit 3 of the lane-1 word, re-enabled before lane 2 of next frame
    data_in = 32'h4433_2211; valid_in = 4'hF;
    word8(8'h11, 1'b1, 1'b0, 4'b0010, "t4_f7l0");
    word8(8'h22, 1'b0, 1'b0, 4'b0000, "t4_f7l1", 3);
    word8(8'h7C, 1'b0, 1'b0, 4'b0000, "t4_f7l2");
    word8(8'h7C, 1'b0, 1'b0, 4'b0000, "t4_f7l3");
    word8(8'h7C, 1'b1, 1'b0, 4'b0000, "t4_f8l0");
    word8(8'h7C, 1'b0, 1'b0, 4'b0000, "t4_f8l1");
    enable = 1'b1;
    #1;
    chk("t4:reenable_ready", {28'd0, ready_out}, 32'b0100);
    word8(8'h33, 1'b0, 1'b0, 4'b1000, "t4_f8l2");
    word8(8'h44, 1'b0, 1'b0, 4'b0001, "t4_f8l3");
    word8(8'h11, 1'b1, 1'b0, 4'b0010, "t4_f9l0");

    // 5: reset asserted at bit 5 of lane-1 word F7 (bit 5 is a 1)
    data_in = 32'h4433_F711;
    wf = 8'hF7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5:pre_bit", {31'd0, data_out}, {31'd0, wf[7-i]});
    end
    @(negedge clk);
    chk("t5:bit5", {31'd0, data_out}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t5:data_out", {31'd0, data_out}, 32'd0);
    chk("t5:sync_done", {31'd0, sync_done}, 32'd0);
    chk("t5:ready_out", {28'd0, ready_out}, 32'd0);
    chk("t5:word_start", {31'd0, word_start}, 32'd0);
    chk("t5:frame_start", {31'd0, frame_start}, 32'd0);
    chk("t5:idle_out", {31'd0, idle_out}, 32'd0);
    chk("t5:state", {31'd0, state_dbg}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    word8(8'hBC, 1'b0, 1'b0, 4'b0000, "t5_com1");
    word8(8'hBC, 1'b0, 1'b0, 4'b0000, "t5_com2");
    word8(8'hBC, 1'b0, 1'b0, 4'b0000, "t5_com3");
    chk("t5:sync_done_pre", {31'd0, sync_done}, 32'd0);
    word8(8'hBC, 1'b0, 1'b0, 4'b0001, "t5_com4");
    word8(8'h11, 1'b1, 1'b0, 4'b0010, "t5_f1l0");

    // 6: LANES=3, WIDTH=10 instance
    data_in3 = {10'h000, 10'h2A5, 10'h000}; valid_in3 = 3'b010;
    reset3 = 1'b1;
    word10(10'h3C5, 1'b0, 3'b000, "t6_com1");
    word10(10'h3C5, 1'b0, 3'b000, "t6_com2");
    word10(10'h3C5, 1'b0, 3'b000, "t6_com3");
    chk("t6:sync_done_pre", {31'd0, sync_done3}, 32'd0);
    word10(10'h3C5, 1'b0, 3'b001, "t6_com4");
    word10(10'h0F0, 1'b1, 3'b010, "t6_f1l0");
    chk("t6:sync_done", {31'd0, sync_done3}, 32'd1);
    word10(10'h2A5, 1'b0, 3'b100, "t6_f1l1");
    word10(10'h0F0, 1'b0, 3'b001, "t6_f1l2");
    word10(10'h0F0, 1'b1, 3'b010, "t6_f2l0");
    chk("t6:idle_out", {31'd0, idle_out3}, 32'd0);
    word10(10'h2A5, 1'b0, 3'b100, "t6_f2l1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
